// File: rtl/regf_mp_if.sv
// regf_mp_if: bus bundle between issue/writeback logic (master) and the
// multi-port register file (slave).
//
// Signalling: there is no valid/ready handshake. Every enable (rd_en[p],
// w_enable[w], busy_set) is a qualifier sampled on each rising clock edge.
// The file never back-pressures, so a request that is asserted at an edge is
// always taken at that edge. rd_data, rd_busy and busy_q are plain register
// outputs, valid after the edge that loaded them.
interface regf_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    logic [NWR-1:0]      w_enable;
    logic [NWR*AW-1:0]   w_addr;
    logic [NWR*XLEN-1:0] w_data;

    logic                busy_set;
    logic [AW-1:0]       busy_set_addr;
    logic [NREG-1:0]     busy_q;

    modport master (
        output rd_en, rd_addr, w_enable, w_addr, w_data, busy_set, busy_set_addr,
        input  rd_data, rd_busy, busy_q
    );

    modport slave (
        input  rd_en, rd_addr, w_enable, w_addr, w_data, busy_set, busy_set_addr,
        output rd_data, rd_busy, busy_q
    );
endinterface

// File: rtl/regf_mp.sv
// regf_mp: multi-port integer register file with registered read ports,
// fixed-priority write ports (highest index wins), optional write-to-read
// bypass and a per-register pending (busy) scoreboard for RAW detection.
module regf_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic     clk,
    input  logic     rstn,
    regf_mp_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]     regs_q [NREG];
    logic [XLEN-1:0]     regs_d [NREG];
    logic [NREG-1:0]     sb_q;
    logic [NREG-1:0]     sb_d;
    logic [NREG-1:0]     wr_hit;

    logic [AW-1:0]       rd_a [NRD];
    logic [AW-1:0]       wr_a [NWR];

    logic [XLEN-1:0]     rd_data_q [NRD];
    logic [XLEN-1:0]     rd_data_d [NRD];
    logic [NRD-1:0]      rd_busy_q;
    logic [NRD-1:0]      rd_busy_d;
    logic [NRD*XLEN-1:0] rd_data_flat;

    // Unpack the flat address buses into per-port arrays.
    for (genvar p = 0; p < NRD; p++) begin : g_rd_addr
        assign rd_a[p] = bus.rd_addr[p*AW +: AW];
    end
    for (genvar w = 0; w < NWR; w++) begin : g_wr_addr
        assign wr_a[w] = bus.w_addr[w*AW +: AW];
    end

    // Resolve write ports per register; later (higher) ports override earlier ones.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wr_hit[r] = 1'b0;
            regs_d[r] = regs_q[r];
            for (int w = 0; w < NWR; w++) begin
                if (bus.w_enable[w] && (wr_a[w] == AW'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
                    wr_hit[r] = 1'b1;
                    regs_d[r] = bus.w_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Scoreboard next state: a new issue (set) outranks a completing write (clear).
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            if (bus.busy_set && (bus.busy_set_addr == AW'(r))) begin
                sb_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                sb_d[r] = 1'b0;
            end else begin
                sb_d[r] = sb_q[r];
            end
            if ((ZERO_REG != 0) && (r == 0)) begin
                sb_d[r] = 1'b0;
            end
        end
    end

    // Read-port next values: bypassed reads look at next state, others at current state.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            if (BYPASS != 0) begin
                rd_data_d[p] = regs_d[rd_a[p]];
                rd_busy_d[p] = sb_d[rd_a[p]];
            end else begin
                rd_data_d[p] = regs_q[rd_a[p]];
                rd_busy_d[p] = sb_q[rd_a[p]];
            end
            if ((ZERO_REG != 0) && (rd_a[p] == '0)) begin
                rd_data_d[p] = '0;
                rd_busy_d[p] = 1'b0;
            end
        end
    end

    // State update: register array, scoreboard and read ports (disabled ports hold).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            sb_q <= '0;
            for (int p = 0; p < NRD; p++) begin
                rd_data_q[p] <= '0;
            end
            rd_busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
            sb_q <= sb_d;
            for (int p = 0; p < NRD; p++) begin
                if (bus.rd_en[p]) begin
                    rd_data_q[p] <= rd_data_d[p];
                    rd_busy_q[p] <= rd_busy_d[p];
                end
            end
        end
    end

    // Pack read data back onto the flat output bus.
    always_comb begin
        rd_data_flat = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data_flat[p*XLEN +: XLEN] = rd_data_q[p];
        end
    end

    assign bus.rd_data = rd_data_flat;
    assign bus.rd_busy = rd_busy_q;
    assign bus.busy_q  = sb_q;
endmodule

// File: tb/tb_regf_mp.sv
// tb_regf_mp: three instances share one clock/reset:
//   A = default parameters (bypass on), B = same but bypass off (driven with
//   A's inputs), C = XLEN 64 / NREG 16 / NRD 3 / NWR 1 with random traffic.
// A rule-level model tracks all three and is compared every cycle; directed
// vectors on A/B also carry hand-computed literal expectations.
module tb_regf_mp;
    logic clk;
    logic rstn;

    regf_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) bus_a ();
    regf_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) bus_b ();
    regf_mp_if #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1)) bus_c ();

    regf_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
    regf_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0))
        dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));
    regf_mp #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1), .ZERO_REG(1), .BYPASS(1))
        dut_c (.clk(clk), .rstn(rstn), .bus(bus_c));

    assign bus_b.rd_en         = bus_a.rd_en;
    assign bus_b.rd_addr       = bus_a.rd_addr;
    assign bus_b.w_enable      = bus_a.w_enable;
    assign bus_b.w_addr        = bus_a.w_addr;
    assign bus_b.w_data        = bus_a.w_data;
    assign bus_b.busy_set      = bus_a.busy_set;
    assign bus_b.busy_set_addr = bus_a.busy_set_addr;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / check ----------------
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;
    bit rand_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Instance k: 0 = A, 1 = B, 2 = C. Register 0 is hard-wired zero everywhere.
    logic [63:0] m_reg  [3][32];
    logic        m_busy [3][32];
    logic [63:0] m_rdd  [3][3];
    logic        m_rdb  [3][3];

    logic        s_ren   [3];
    int          s_raddr [3];
    logic        s_we    [2];
    int          s_waddr [2];
    logic [63:0] s_wdata [2];
    logic        s_bs;
    int          s_bsa;

    // One clock edge of the file, from the behavioural rules.
    task automatic model_step(input int k, input int nrd, input int nwr, input bit byp);
        logic [63:0] nv [32];
        logic        nb [32];
        for (int i = 0; i < 32; i++) begin
            nv[i] = m_reg[k][i];
            nb[i] = m_busy[k][i];
        end
        // ports applied in order, so the highest-index port to an address wins
        for (int w = 0; w < nwr; w++) begin
            if (s_we[w] && s_waddr[w] != 0) begin
                nv[s_waddr[w]] = s_wdata[w];
                nb[s_waddr[w]] = 1'b0;
            end
        end
        if (s_bs && s_bsa != 0) nb[s_bsa] = 1'b1;
        for (int p = 0; p < nrd; p++) begin
            if (s_ren[p]) begin
                if (s_raddr[p] == 0) begin
                    m_rdd[k][p] = 64'd0;
                    m_rdb[k][p] = 1'b0;
                end else if (byp) begin
                    m_rdd[k][p] = nv[s_raddr[p]];
                    m_rdb[k][p] = nb[s_raddr[p]];
                end else begin
                    m_rdd[k][p] = m_reg[k][s_raddr[p]];
                    m_rdb[k][p] = m_busy[k][s_raddr[p]];
                end
            end
        end
        for (int i = 0; i < 32; i++) begin
            m_reg[k][i]  = nv[i];
            m_busy[k][i] = nb[i];
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 32; i++) begin
                    m_reg[k][i]  = 64'd0;
                    m_busy[k][i] = 1'b0;
                end
                for (int p = 0; p < 3; p++) begin
                    m_rdd[k][p] = 64'd0;
                    m_rdb[k][p] = 1'b0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                s_ren[p]   = bus_a.rd_en[p];
                s_raddr[p] = int'(bus_a.rd_addr[p*5 +: 5]);
                s_we[p]    = bus_a.w_enable[p];
                s_waddr[p] = int'(bus_a.w_addr[p*5 +: 5]);
                s_wdata[p] = {32'd0, bus_a.w_data[p*32 +: 32]};
            end
            s_ren[2] = 1'b0;
            s_raddr[2] = 0;
            s_bs  = bus_a.busy_set;
            s_bsa = int'(bus_a.busy_set_addr);
            model_step(0, 2, 2, 1'b1);
            model_step(1, 2, 2, 1'b0);
            for (int p = 0; p < 3; p++) begin
                s_ren[p]   = bus_c.rd_en[p];
                s_raddr[p] = int'(bus_c.rd_addr[p*4 +: 4]);
            end
            s_we[0]    = bus_c.w_enable[0];
            s_waddr[0] = int'(bus_c.w_addr);
            s_wdata[0] = bus_c.w_data;
            s_we[1]    = 1'b0;
            s_bs  = bus_c.busy_set;
            s_bsa = int'(bus_c.busy_set_addr);
            model_step(2, 3, 1, 1'b1);
        end
    end

    // ---------------- per-cycle compare (away from the active edge) ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            logic [31:0] eb32;
            logic [31:0] eb32b;
            logic [15:0] eb16;
            for (int r = 0; r < 32; r++) begin
                eb32[r]  = m_busy[0][r];
                eb32b[r] = m_busy[1][r];
            end
            for (int r = 0; r < 16; r++) eb16[r] = m_busy[2][r];
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("A.rd_data[%0d]", p), {32'd0, bus_a.rd_data[p*32 +: 32]}, m_rdd[0][p]);
                chk($sformatf("A.rd_busy[%0d]", p), {63'd0, bus_a.rd_busy[p]}, {63'd0, m_rdb[0][p]});
                chk($sformatf("B.rd_data[%0d]", p), {32'd0, bus_b.rd_data[p*32 +: 32]}, m_rdd[1][p]);
                chk($sformatf("B.rd_busy[%0d]", p), {63'd0, bus_b.rd_busy[p]}, {63'd0, m_rdb[1][p]});
            end
            chk("A.busy_q", {32'd0, bus_a.busy_q}, {32'd0, eb32});
            chk("B.busy_q", {32'd0, bus_b.busy_q}, {32'd0, eb32b});
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("C.rd_data[%0d]", p), bus_c.rd_data[p*64 +: 64], m_rdd[2][p]);
                chk($sformatf("C.rd_busy[%0d]", p), {63'd0, bus_c.rd_busy[p]}, {63'd0, m_rdb[2][p]});
            end
            chk("C.busy_q", {48'd0, bus_c.busy_q}, {48'd0, eb16});
        end
    end

    // ---------------- driver tasks (instance A, mirrored to B) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus_a.rd_en    = '0;
        bus_a.w_enable = '0;
        bus_a.busy_set = 1'b0;
    endtask

    task automatic wr(input int port, input int addr, input logic [31:0] data);
        bus_a.w_enable[port]        = 1'b1;
        bus_a.w_addr[port*5 +: 5]   = 5'(addr);
        bus_a.w_data[port*32 +: 32] = data;
    endtask

    task automatic rd(input int port, input int addr, input logic en);
        bus_a.rd_en[port]          = en;
        bus_a.rd_addr[port*5 +: 5] = 5'(addr);
    endtask

    task automatic bset(input int addr);
        bus_a.busy_set      = 1'b1;
        bus_a.busy_set_addr = 5'(addr);
    endtask

    // ---------------- random traffic on instance C ----------------
    initial begin
        bus_c.rd_en = '0;
        bus_c.rd_addr = '0;
        bus_c.w_enable = '0;
        bus_c.w_addr = '0;
        bus_c.w_data = '0;
        bus_c.busy_set = 1'b0;
        bus_c.busy_set_addr = '0;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            bus_c.rd_en = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) bus_c.rd_addr[p*4 +: 4] = 4'($urandom_range(0, 15));
            bus_c.w_enable = 1'($urandom_range(0, 1));
            bus_c.w_addr   = 4'($urandom_range(0, 15));
            bus_c.w_data   = {$urandom, $urandom};
            bus_c.busy_set = ($urandom_range(0, 3) == 0);
            bus_c.busy_set_addr = 4'($urandom_range(0, 15));
        end
        rand_done = 1'b1;
    end

    // ---------------- directed sequence ----------------
    initial begin
        rstn = 1'b1;
        bus_a.rd_addr = '0;
        bus_a.w_addr = '0;
        bus_a.w_data = '0;
        bus_a.busy_set_addr = '0;
        clr();
        #2 rstn = 1'b0;
        step();
        chk_on = 1'b1;
        step();
        chk("reset rd_data", {32'd0, bus_a.rd_data}, 64'd0);
        chk("reset busy_q", {32'd0, bus_a.busy_q}, 64'd0);
        rstn = 1'b1;

        // Reset: write r5, mark r7 busy, read r5 back, then reset mid-cycle.
        wr(0, 5, 32'h12345678); bset(7); step();
        clr(); rd(0, 5, 1'b1); step();
        chk("r5 before reset", {32'd0, bus_a.rd_data[31:0]}, 64'h12345678);
        chk("busy7 before reset", {63'd0, bus_a.busy_q[7]}, 64'd1);
        clr();
        #2 rstn = 1'b0;
        #1;
        chk("async rst rd_data", {32'd0, bus_a.rd_data}, 64'd0);
        chk("async rst busy_q", {32'd0, bus_a.busy_q}, 64'd0);
        step();
        rstn = 1'b1;
        rd(0, 5, 1'b1); step();
        chk("r5 after reset", {32'd0, bus_a.rd_data[31:0]}, 64'd0);

        // Basic write/read and the zero register.
        clr(); wr(0, 3, 32'hDEADBEEF); step();
        clr(); rd(1, 3, 1'b1); step();
        chk("r3 on port1", {32'd0, bus_a.rd_data[63:32]}, 64'hDEADBEEF);
        clr(); wr(0, 0, 32'hFFFFFFFF); step();
        clr(); rd(0, 0, 1'b1); step();
        chk("r0 reads 0", {32'd0, bus_a.rd_data[31:0]}, 64'd0);

        // Write conflict and bypass.
        clr(); wr(0, 7, 32'h9); step();
        clr(); wr(0, 7, 32'h1); wr(1, 7, 32'h2); rd(0, 7, 1'b1); step();
        chk("conflict bypass on", {32'd0, bus_a.rd_data[31:0]}, 64'h2);
        chk("conflict bypass off", {32'd0, bus_b.rd_data[31:0]}, 64'h9);
        clr(); rd(0, 7, 1'b1); step();
        chk("conflict winner A", {32'd0, bus_a.rd_data[31:0]}, 64'h2);
        chk("conflict winner B", {32'd0, bus_b.rd_data[31:0]}, 64'h2);

        // Stall hold.
        clr(); wr(0, 4, 32'hA); wr(1, 6, 32'hB); step();
        clr(); rd(0, 4, 1'b1); step();
        chk("stall first read", {32'd0, bus_a.rd_data[31:0]}, 64'hA);
        for (int i = 0; i < 3; i++) begin
            rd(0, 6, 1'b0); step();
            chk("stall hold", {32'd0, bus_a.rd_data[31:0]}, 64'hA);
        end
        rd(0, 6, 1'b1); step();
        chk("stall release", {32'd0, bus_a.rd_data[31:0]}, 64'hB);

        // Scoreboard.
        clr(); bset(9); step();
        chk("busy9 set", {63'd0, bus_a.busy_q[9]}, 64'd1);
        clr(); rd(0, 9, 1'b1); step();
        chk("rd_busy r9", {63'd0, bus_a.rd_busy[0]}, 64'd1);
        clr(); wr(0, 9, 32'h55); rd(0, 9, 1'b1); step();
        chk("busy9 cleared", {63'd0, bus_a.busy_q[9]}, 64'd0);
        chk("clr rd_busy bypass", {63'd0, bus_a.rd_busy[0]}, 64'd0);
        chk("clr rd_busy nobypass", {63'd0, bus_b.rd_busy[0]}, 64'd1);
        chk("clr rd_data bypass", {32'd0, bus_a.rd_data[31:0]}, 64'h55);
        chk("clr rd_data nobypass", {32'd0, bus_b.rd_data[31:0]}, 64'h0);
        clr(); bset(9); wr(1, 9, 32'h66); step();
        chk("set beats clear", {63'd0, bus_a.busy_q[9]}, 64'd1);
        clr(); rd(1, 9, 1'b1); step();
        chk("r9 data with set", {32'd0, bus_a.rd_data[63:32]}, 64'h66);
        chk("r9 busy with set", {63'd0, bus_a.rd_busy[1]}, 64'd1);
        clr(); bset(0); step();
        chk("busy0 stays 0", {63'd0, bus_a.busy_q[0]}, 64'd0);
        clr();

        // Wait (bounded) for the random traffic on C to finish.
        for (int i = 0; i < 12000 && !rand_done; i++) step();
        if (!rand_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL random run timeout: got not-done expected done");
        end
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
